// File: rtl/mesi_bus_controller.sv
// MESI bus controller: turns miss/upgrade pulses from the MESI machine
// into snooping-bus transactions (arbitrate, write back, issue, wait).
//
// Ports:
//   Clock, ResetN            clock, async active-low reset
//   ReadMiss/WriteMiss/Invalid  one-cycle command pulses
//   WriteBack                dirty-victim qualifier, latched with the miss
//   ReqAddr/VictimAddr/WbData   miss address, victim address and data
//   BusGrant/BusShared/MemAck   arbiter grant, snoop response, mem done
//   BusReq/BusCmd/BusAddr/BusData  bus request and command outputs
//   NoShared                 ~SharedSeen, updated on every completion
//   Busy/Done/Error/ReqDropped  status pulses and levels
module mesi_bus_controller #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  ReadMiss,
  input  logic                  WriteMiss,
  input  logic                  Invalid,
  input  logic                  WriteBack,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [ADDR_WIDTH-1:0] VictimAddr,
  input  logic [DATA_WIDTH-1:0] WbData,
  input  logic                  BusGrant,
  input  logic                  BusShared,
  input  logic                  MemAck,
  output logic                  BusReq,
  output logic [2:0]            BusCmd,
  output logic [ADDR_WIDTH-1:0] BusAddr,
  output logic [DATA_WIDTH-1:0] BusData,
  output logic                  NoShared,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic                  ReqDropped
);

  localparam int CW =
    (TIMEOUT < 3) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT - 1);

  localparam logic [2:0] CMD_NONE = 3'b000;
  localparam logic [2:0] CMD_RD   = 3'b001;
  localparam logic [2:0] CMD_RDX  = 3'b010;
  localparam logic [2:0] CMD_UPGR = 3'b011;
  localparam logic [2:0] CMD_WB   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WB,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            cmd_q, cmd_d;
  logic                  wb_q;
  logic                  shared_q;
  logic [ADDR_WIDTH-1:0] req_q;
  logic [ADDR_WIDTH-1:0] vic_q;
  logic [DATA_WIDTH-1:0] dat_q;

  logic any_req;
  logic cap;
  logic tmo;
  logic shared_now;
  logic in_timed;

  always_comb begin
    any_req = ReadMiss | WriteMiss | Invalid;
    cap     = (state_q == S_IDLE) & any_req;
    state_d = state_q;
    tmo     = 1'b0;
    cnt_d   = '0;

    // WriteMiss wins, then ReadMiss, then Invalid
    if (WriteMiss)     cmd_d = CMD_RDX;
    else if (ReadMiss) cmd_d = CMD_RD;
    else               cmd_d = CMD_UPGR;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_REQ;
      end
      S_REQ: begin
        if (BusGrant)
          state_d = wb_q ? S_WB : S_ISSUE;
      end
      S_WB: begin
        if (MemAck) begin
          state_d = S_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          tmo     = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = (cmd_q == CMD_UPGR)
                ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (MemAck) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          tmo     = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // counter restarts on every entry into WB or WAIT
    in_timed = (state_q == S_WB)
             | (state_q == S_WAIT);
    if (in_timed && state_d == state_q)
      cnt_d = cnt_q + 1'b1;

    shared_now = BusShared &
      ((state_q == S_ISSUE) |
       (state_q == S_WAIT));
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= CMD_NONE;
      wb_q       <= 1'b0;
      shared_q   <= 1'b0;
      req_q      <= '0;
      vic_q      <= '0;
      dat_q      <= '0;
      BusReq     <= 1'b0;
      BusCmd     <= CMD_NONE;
      BusAddr    <= '0;
      BusData    <= '0;
      NoShared   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      ReqDropped <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (cap) begin
        cmd_q    <= cmd_d;
        wb_q     <= WriteBack;
        req_q    <= ReqAddr;
        vic_q    <= VictimAddr;
        dat_q    <= WbData;
        shared_q <= 1'b0;
      end else if (shared_now) begin
        shared_q <= 1'b1;
      end

      BusReq <= (state_d == S_REQ)
              | (state_d == S_WB)
              | (state_d == S_ISSUE)
              | (state_d == S_WAIT);

      unique case (state_d)
        S_WB: begin
          BusCmd  <= CMD_WB;
          BusAddr <= vic_q;
          BusData <= dat_q;
        end
        S_ISSUE: begin
          BusCmd  <= cmd_q;
          BusAddr <= req_q;
          BusData <= '0;
        end
        S_WAIT: begin
          BusCmd  <= CMD_NONE;
          BusAddr <= req_q;
          BusData <= '0;
        end
        default: begin
          BusCmd  <= CMD_NONE;
          BusAddr <= '0;
          BusData <= '0;
        end
      endcase

      Busy       <= (state_d != S_IDLE);
      Done       <= (state_d == S_DONE);
      Error      <= tmo;
      ReqDropped <= any_req &
                    (state_q != S_IDLE);

      // fold in the snoop seen on the completing edge
      if (state_d == S_DONE)
        NoShared <= ~(shared_q | shared_now);
    end
  end

endmodule

// File: tb/tb_mesi_bus_controller.sv
// Self-checking bench for mesi_bus_controller: builds an expected
// cycle trace per transaction from the protocol rules.
module tb_mesi_bus_controller;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic       ReadMiss, WriteMiss, Invalid;
  logic       WriteBack;
  logic [7:0] ReqAddr, VictimAddr, WbData;
  logic       BusGrant, BusShared, MemAck;
  logic       BusReq;
  logic [2:0] BusCmd;
  logic [7:0] BusAddr, BusData;
  logic       NoShared, Busy, Done;
  logic       Error, ReqDropped;

  int n_chk  = 0;
  int n_fail = 0;
  bit ns_m   = 1'b0;

  localparam int P_REQ  = 0;
  localparam int P_WB   = 1;
  localparam int P_ISS  = 2;
  localparam int P_WAIT = 3;
  localparam int P_DONE = 4;
  localparam int P_ERR  = 5;
  localparam int P_IDLE = 6;

  mesi_bus_controller dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .ReadMiss   (ReadMiss),
    .WriteMiss  (WriteMiss),
    .Invalid    (Invalid),
    .WriteBack  (WriteBack),
    .ReqAddr    (ReqAddr),
    .VictimAddr (VictimAddr),
    .WbData     (WbData),
    .BusGrant   (BusGrant),
    .BusShared  (BusShared),
    .MemAck     (MemAck),
    .BusReq     (BusReq),
    .BusCmd     (BusCmd),
    .BusAddr    (BusAddr),
    .BusData    (BusData),
    .NoShared   (NoShared),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error),
    .ReqDropped (ReqDropped)
  );

  always #5 Clock = ~Clock;

  function automatic logic [24:0] outs();
    return {BusReq, BusCmd, BusAddr, BusData,
            Busy, Done, Error, NoShared,
            ReqDropped};
  endfunction

  task automatic idle_inputs();
    ReadMiss   = 0;
    WriteMiss  = 0;
    Invalid    = 0;
    WriteBack  = 0;
    BusGrant   = 0;
    BusShared  = 0;
    MemAck     = 0;
  endtask

  // g: REQ cycles before grant; a1: WB ack delay (-1 = timeout);
  // a2: WAIT ack delay (-1 = timeout); shm: 0 random noise,
  // 1 no snoop hits, 2 snoop hit during WAIT only.
  task automatic run_txn(
    input string nm,
    input bit wm, input bit rm,
    input bit inv, input bit wbf,
    input int g, input int a1, input int a2,
    input int shm, input int drop_in,
    input logic [7:0] ra, input logic [7:0] va,
    input logic [7:0] wd);
    int ph[100];
    bit gn[100], ak[100], sh[100];
    int n, di, nbusy, dr, p;
    bit err, so, new_ns;
    logic [2:0] ecmd;
    logic [24:0] ex, ob;
    logic e_req, e_busy, e_done, e_err;
    logic [2:0] e_cmd;
    logic [7:0] e_addr, e_data;

    ecmd = wm ? 3'b010 : (rm ? 3'b001 : 3'b011);
    n = 0; di = -1; err = 0;
    for (int k = 0; k <= g; k++) begin
      ph[n] = P_REQ; gn[n] = (k == g);
      ak[n] = (shm == 0) ? 1'($urandom) : 1'b0;
      sh[n] = (shm == 0) ? 1'($urandom) : 1'b0;
      n++;
    end
    if (wbf) begin
      if (a1 < 0) begin
        for (int k = 0; k < 15; k++) begin
          ph[n] = P_WB; gn[n] = 1; ak[n] = 0;
          sh[n] = (shm == 0) ? 1'($urandom) : 1'b0;
          n++;
        end
        err = 1;
      end else begin
        for (int k = 0; k <= a1; k++) begin
          ph[n] = P_WB; gn[n] = 1; ak[n] = (k == a1);
          sh[n] = (shm == 0) ? 1'($urandom) : 1'b0;
          n++;
        end
      end
    end
    if (!err) begin
      ph[n] = P_ISS; gn[n] = 1;
      ak[n] = (shm == 0) ? 1'($urandom) : 1'b0;
      sh[n] = (shm == 0) ? 1'($urandom) : 1'b0;
      n++;
      if (ecmd != 3'b011) begin
        if (a2 < 0) begin
          for (int k = 0; k < 15; k++) begin
            ph[n] = P_WAIT; gn[n] = 1; ak[n] = 0;
            sh[n] = (shm == 0) ? 1'($urandom)
                  : (shm == 2);
            n++;
          end
          err = 1;
        end else begin
          for (int k = 0; k <= a2; k++) begin
            ph[n] = P_WAIT; gn[n] = 1;
            ak[n] = (k == a2);
            sh[n] = (shm == 0) ? 1'($urandom)
                  : (shm == 2);
            n++;
          end
        end
      end
    end
    if (err) begin
      ph[n] = P_ERR; gn[n] = 0; ak[n] = 0; sh[n] = 0;
      n++;
    end else begin
      di = n;
      ph[n] = P_DONE; gn[n] = 0;
      ak[n] = (shm == 0) ? 1'($urandom) : 1'b0;
      sh[n] = (shm == 0) ? 1'($urandom) : 1'b0;
      n++;
    end

    so = 0;
    for (int k = 0; k < n; k++)
      if (ph[k] == P_ISS || ph[k] == P_WAIT)
        so = so | sh[k];
    new_ns = err ? ns_m : ~so;
    nbusy = err ? n - 1 : n;
    dr = (drop_in >= 0) ? drop_in % nbusy : -1;

    @(negedge Clock);
    ReadMiss = rm; WriteMiss = wm; Invalid = inv;
    WriteBack = wbf; ReqAddr = ra;
    VictimAddr = va; WbData = wd;
    BusGrant = 0; MemAck = 0;
    BusShared = 1'($urandom);

    for (int i = 0; i <= n; i++) begin
      @(negedge Clock);
      p = (i < n) ? ph[i] : P_IDLE;
      e_req = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_cmd = 3'b000; e_addr = 8'h00; e_data = 8'h00;
      case (p)
        P_REQ:  begin e_req = 1; e_busy = 1; end
        P_WB:   begin
          e_req = 1; e_busy = 1; e_cmd = 3'b100;
          e_addr = va; e_data = wd;
        end
        P_ISS:  begin
          e_req = 1; e_busy = 1; e_cmd = ecmd;
          e_addr = ra;
        end
        P_WAIT: begin
          e_req = 1; e_busy = 1; e_addr = ra;
        end
        P_DONE: begin e_busy = 1; e_done = 1; end
        P_ERR:  begin e_err = 1; end
        default: ;
      endcase
      ex = {e_req, e_cmd, e_addr, e_data,
            e_busy, e_done, e_err,
            (di >= 0 && i >= di) ? new_ns : ns_m,
            (dr >= 0 && i == dr + 1)};
      ob = outs();
      n_chk++;
      if (ob !== ex) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %h want %h",
                 nm, i, ob, ex);
      end
      ReadMiss = (i == dr);
      WriteMiss = 0; Invalid = 0;
      WriteBack = 1'($urandom);
      ReqAddr = 8'($urandom);
      VictimAddr = 8'($urandom);
      WbData = 8'($urandom);
      BusGrant  = (i < n) ? gn[i] : 1'b0;
      MemAck    = (i < n) ? ak[i] : 1'b0;
      BusShared = (i < n) ? sh[i] : 1'b0;
    end
    idle_inputs();
    ns_m = new_ns;
  endtask

  task automatic test_reset();
    ResetN = 0;
    idle_inputs();
    ReqAddr = 8'h00; VictimAddr = 8'h00; WbData = 8'h00;
    repeat (3) @(negedge Clock);
    n_chk++;
    if (outs() !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", outs());
    end
    ResetN = 1;
    ns_m = 0;
  endtask

  task automatic test_read_basic();
    run_txn("read_noshare", 0, 1, 0, 0,
            0, 0, 1, 1, -1, 8'h3C, 8'h00, 8'h00);
  endtask

  task automatic test_read_shared();
    run_txn("read_shared", 0, 1, 0, 0,
            0, 0, 1, 2, -1, 8'h3C, 8'h00, 8'h00);
  endtask

  task automatic test_writeback();
    run_txn("wm_writeback", 1, 0, 0, 1,
            3, 2, 2, 1, -1, 8'h22, 8'h11, 8'hA5);
  endtask

  task automatic test_upgrade();
    run_txn("upgrade", 0, 0, 1, 0,
            0, 0, 0, 1, -1, 8'h47, 8'h00, 8'h00);
  endtask

  task automatic test_priority();
    run_txn("prio_wm_rm", 1, 1, 0, 0,
            1, 0, 0, 0, -1, 8'h90, 8'h00, 8'h00);
    run_txn("prio_rm_inv", 0, 1, 1, 0,
            0, 0, 2, 0, -1, 8'h91, 8'h00, 8'h00);
    run_txn("prio_all", 1, 1, 1, 0,
            0, 0, 0, 0, -1, 8'h92, 8'h00, 8'h00);
  endtask

  task automatic test_timeout();
    run_txn("wait_timeout", 0, 1, 0, 0,
            0, 0, -1, 0, -1, 8'h5E, 8'h00, 8'h00);
    run_txn("wb_timeout", 1, 0, 0, 1,
            1, -1, 0, 0, -1, 8'h6E, 8'h33, 8'h44);
  endtask

  task automatic test_drop();
    run_txn("drop_wait", 0, 1, 0, 0,
            0, 0, 3, 0, 3, 8'h71, 8'h00, 8'h00);
    run_txn("drop_done", 0, 1, 0, 0,
            0, 0, 1, 1, 4, 8'h72, 8'h00, 8'h00);
  endtask

  task automatic test_wb_alone();
    @(negedge Clock);
    WriteBack = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      n_chk++;
      if (Busy !== 1'b0 || BusReq !== 1'b0) begin
        n_fail++;
        $display("FAIL wb_alone cyc %0d: got busy %b req %b want 0 0",
                 i, Busy, BusReq);
      end
    end
    WriteBack = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge Clock);
    ReadMiss = 1; ReqAddr = 8'h5A; BusGrant = 1;
    @(negedge Clock);
    ReadMiss = 0;
    repeat (2) @(negedge Clock);
    n_chk++;
    if (Busy !== 1'b1 || BusAddr !== 8'h5A) begin
      n_fail++;
      $display("FAIL rst_pre: got busy %b addr %h want 1 5a",
               Busy, BusAddr);
    end
    ResetN = 0;
    #1;
    n_chk++;
    if (outs() !== 25'h0) begin
      n_fail++;
      $display("FAIL rst_async: got %h want 0", outs());
    end
    @(negedge Clock);
    n_chk++;
    if (outs() !== 25'h0) begin
      n_fail++;
      $display("FAIL rst_hold: got %h want 0", outs());
    end
    ResetN = 1;
    idle_inputs();
    ns_m = 0;
    run_txn("post_reset", 0, 1, 0, 0,
            1, 0, 2, 0, -1, 8'hC3, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    bit wm, rm, inv;
    int a1, a2, dr;
    for (int t = 0; t < 40; t++) begin
      wm = 1'($urandom); rm = 1'($urandom);
      inv = 1'($urandom);
      if (!(wm | rm | inv)) inv = 1;
      a1 = ($urandom_range(0, 9) == 0)
         ? -1 : int'($urandom_range(0, 6));
      a2 = ($urandom_range(0, 9) == 0)
         ? -1 : int'($urandom_range(0, 12));
      dr = ($urandom_range(0, 1) == 0)
         ? -1 : int'($urandom_range(0, 40));
      run_txn("random", wm, rm, inv,
              1'($urandom),
              $urandom_range(0, 4), a1, a2, 0, dr,
              8'($urandom), 8'($urandom),
              8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_shared();
    test_writeback();
    test_upgrade();
    test_priority();
    test_timeout();
    test_drop();
    test_wb_alone();
    test_read_basic();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mesi_bus_controller.md
Name: mesi_bus_controller

Overview:
- Consumes the one-cycle command pulses (ReadMiss, WriteMiss, Invalid, WriteBack) from the processor-side MESI state machine and turns each into a snooping-bus transaction: arbitration, optional victim write-back, command issue, then wait for memory.
- Returns NoShared to the MESI machine, used for the I->E vs I->S decision on read misses.
- One outstanding transaction at a time; sits between the MESI machine and the shared bus/arbiter.

Parameters:
- ADDR_WIDTH, 8, width of line addresses.
- DATA_WIDTH, 8, width of write-back data.
- TIMEOUT, 15, maximum cycles spent in WAIT before abort; a 4-bit counter is sufficient at the default.

Ports:
- Clock  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- ReadMiss  in  1  pulse from the MESI machine.
- WriteMiss  in  1  pulse from the MESI machine.
- Invalid  in  1  pulse from the MESI machine: upgrade/invalidate request.
- WriteBack  in  1  qualifier: a dirty victim must be written first.
- ReqAddr  in  ADDR_WIDTH  line address of the miss.
- VictimAddr  in  ADDR_WIDTH  address of the dirty victim.
- WbData  in  DATA_WIDTH  victim data.
- BusGrant  in  1  arbiter grant; held by the arbiter while BusReq is high.
- BusShared  in  1  wired-OR snoop response from the other caches.
- MemAck  in  1  memory completion, one-cycle pulse.
- BusReq  out  1  bus request.
- BusCmd  out  3  bus command: 000 none, 001 BusRd, 010 BusRdX, 011 BusUpgr, 100 BusWB.
- BusAddr  out  ADDR_WIDTH  bus address.
- BusData  out  DATA_WIDTH  write-back data.
- NoShared  out  1  to the MESI machine.
- Busy  out  1  transaction in flight.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  one-cycle timeout pulse.
- ReqDropped  out  1  one-cycle pulse: a request arrived while Busy.

Behaviour:
- General
  - All outputs are registered (Moore, decoded from the next state).
  - Reset value of every output is 0. The state returns to IDLE and all latches clear immediately on ResetN=0, including mid-transaction; no bus command is driven after reset.
- Capture (IDLE only)
  - Any of ReadMiss/WriteMiss/Invalid high at a rising edge latches the command.
  - Priority when several are high: WriteMiss (BusRdX) > ReadMiss (BusRd) > Invalid (BusUpgr).
  - WriteBack is latched together with ReqAddr, VictimAddr and WbData.
  - SharedSeen is cleared. Next state is REQ.
  - WriteBack alone (no miss/invalid) is ignored.
- Busy is 1 in every state except IDLE.
- REQ: BusReq=1, BusCmd=000. Hold until BusGrant=1, then go to WB if WriteBack was latched, else ISSUE. Grant is sampled only in REQ.
- WB: BusReq=1, BusCmd=100, BusAddr=VictimAddr, BusData=WbData.
  - Hold until MemAck, then go to ISSUE.
  - The timeout counter runs here, same rule as WAIT.
- ISSUE (exactly 1 cycle): BusReq=1, BusCmd=latched command, BusAddr=ReqAddr.
  - BusUpgr goes next to DONE; BusRd/BusRdX go to WAIT.
- WAIT: BusReq=1, BusCmd=000, BusAddr held.
  - MemAck goes to DONE.
  - Counter increments each WAIT/WB cycle. When it reaches TIMEOUT without MemAck: Error=1 for one cycle, BusReq drops, go to IDLE, NoShared unchanged.
- SharedSeen: OR of BusShared sampled during ISSUE and WAIT.
- DONE (1 cycle): Done=1, BusReq=0, NoShared = ~SharedSeen, then IDLE.
  - For BusRdX/BusUpgr, NoShared is still updated but carries no meaning.
  - NoShared holds until the next DONE or reset.
- Request while Busy (including the DONE cycle): ReqDropped=1 for one cycle, request discarded, current transaction unaffected.
- MemAck arriving outside WB/WAIT is ignored.
- BusShared outside ISSUE/WAIT is ignored.
- Latency: with grant already high and no write-back, a pulse at edge 0 gives REQ at cycle 1, ISSUE at cycle 2, WAIT from cycle 3; MemAck at cycle k gives Done at cycle k+1.

Test Plan:
- Reset: ResetN=0 during WAIT -> next cycle all outputs 0, Busy=0; a later ReadMiss starts cleanly from REQ.
- ReadMiss, ReqAddr=0x3C, BusGrant=1, BusShared=0, MemAck 2 cycles after ISSUE -> BusCmd=001/BusAddr=0x3C for exactly one cycle; Done=1 with NoShared=1; BusReq=0 in the Done cycle.
- Same as above with BusShared=1 during WAIT -> NoShared=0 at Done.
- WriteMiss+WriteBack, VictimAddr=0x11, WbData=0xA5, ReqAddr=0x22, grant delayed 3 cycles -> BusReq high 3 cycles with BusCmd=000; then BusCmd=100/0x11/0xA5 until MemAck; then BusCmd=010/0x22; Done after the second MemAck.
- Invalid only -> BusCmd=011 for one cycle, Done the next cycle, no MemAck needed. WriteMiss+ReadMiss together -> BusCmd=010 chosen.
- No MemAck in WAIT -> Error=1 after TIMEOUT=15 WAIT cycles, no Done, Busy=0 the next cycle. ReadMiss during Busy -> ReqDropped=1 pulse, transaction unaffected.
